// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with IF/ID register (optional FETCH_PERF_EN counters)
module fetch_stage #(
    parameter int                      ADDRESS_WIDTH = 32,
    parameter int                      DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     halt,
    input  logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic                     valid_d,
    output logic                     misalign_err,
    output logic                     halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              fetch_count,
    output logic [31:0]              stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDRESS_WIDTH-1:0] pc_nxt;
    logic [ADDRESS_WIDTH-1:0] pc_d_nxt;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d_nxt;
    logic [DATA_WIDTH-1:0]    instr_d_nxt;
    logic                     valid_d_nxt;
    logic                     misalign_nxt;
    logic                     advance;
    logic                     stall_evt;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;

    assign pc_plus4    = pc + ADDRESS_WIDTH'(4);
    // Low target bits are always dropped; misalignment is only reported.
    assign redirect_pc = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
    assign halted      = (state == ST_HALT);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pc_d_nxt       = pc_d;
        pc_plus4_d_nxt = pc_plus4_d;
        instr_d_nxt    = instr_d;
        valid_d_nxt    = valid_d;
        advance        = 1'b0;
        stall_evt      = 1'b0;
        misalign_nxt   = misalign_err | (redirect & (redirect_target[1:0] != 2'b00));

        case (state)
            ST_BOOT: begin
                instr_d_nxt = NOP_INSTR;
                valid_d_nxt = 1'b0;
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_nxt      = redirect_pc;
                    instr_d_nxt = NOP_INSTR;
                    valid_d_nxt = 1'b0;
                end else if (stall) begin
                    stall_evt = 1'b1;
                end else begin
                    advance        = 1'b1;
                    pc_nxt         = pc_plus4;
                    pc_d_nxt       = pc;
                    pc_plus4_d_nxt = pc_plus4;
                    instr_d_nxt    = instr;
                    valid_d_nxt    = 1'b1;
                end
                if (halt && !redirect) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                instr_d_nxt = NOP_INSTR;
                valid_d_nxt = 1'b0;
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_BOOT;
            pc           <= RESET_VECTOR;
            pc_d         <= '0;
            pc_plus4_d   <= '0;
            instr_d      <= NOP_INSTR;
            valid_d      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            pc_d         <= pc_d_nxt;
            pc_plus4_d   <= pc_plus4_d_nxt;
            instr_d      <= instr_d_nxt;
            valid_d      <= valid_d_nxt;
            misalign_err <= misalign_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (advance && (fetch_count != 32'hFFFFFFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall_evt && (stall_count != 32'hFFFFFFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    logic unused_evt;
    assign unused_evt = advance ^ stall_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        misalign_err;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] rom [0:1023];
    assign instr = rom[pc[11:2]];

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .instr           (instr),
        .pc              (pc),
        .pc_d            (pc_d),
        .pc_plus4_d      (pc_plus4_d),
        .instr_d         (instr_d),
        .valid_d         (valid_d),
        .misalign_err    (misalign_err),
        .halted          (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcd;
        logic [31:0] pc4d;
        logic [31:0] instrd;
        logic        valid;
        logic        err;
        logic        halted;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   failed;

    // Reference model: mode 0 = just out of reset, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4d;
    logic [31:0] m_instrd;
    logic        m_valid;
    logic        m_err;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic rd,
                              input logic [31:0] tgt, input logic h);
        exp_t e;
        if (r) begin
            m_mode = 0; m_pc = RV; m_pcd = 0; m_pc4d = 0; m_instrd = NOP;
            m_valid = 0; m_err = 0; m_fc = 0; m_sc = 0;
        end else begin
            if (rd && tgt[1:0] != 2'b00) m_err = 1;
            if (rd || m_mode != 1) begin
                if (rd) m_pc = tgt & 32'hFFFFFFFC;
                m_instrd = NOP;
                m_valid  = 0;
                if (m_mode == 0 || rd) m_mode = 1;
                else if (m_mode == 1 && h) m_mode = 2;
            end else if (s) begin
                if (m_sc != 32'hFFFFFFFF) m_sc = m_sc + 1;
                if (h) m_mode = 2;
            end else begin
                m_instrd = rom[m_pc[11:2]];
                m_pcd    = m_pc;
                m_pc4d   = m_pc + 4;
                m_pc     = m_pc + 4;
                m_valid  = 1;
                if (m_fc != 32'hFFFFFFFF) m_fc = m_fc + 1;
                if (h) m_mode = 2;
            end
        end
        e.pc = m_pc; e.pcd = m_pcd; e.pc4d = m_pc4d; e.instrd = m_instrd;
        e.valid = m_valid; e.err = m_err; e.halted = (m_mode == 2);
        e.fc = m_fc; e.sc = m_sc;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic rd,
                       input logic [31:0] tgt, input logic h);
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_target = tgt; halt = h;
        model_edge(r, s, rd, tgt, h);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_d", pc_d, e.pcd);
                chk("pc_plus4_d", pc_plus4_d, e.pc4d);
                chk("instr_d", instr_d, e.instrd);
                chk("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
                chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
                chk("halted", {31'd0, halted}, {31'd0, e.halted});
`ifdef FETCH_PERF_EN
                chk("fetch_count", fetch_count, e.fc);
                chk("stall_count", stall_count, e.sc);
`endif
            end
        end
    end

    initial begin : driver
        logic [31:0] tgt;
        tests = 0; failed = 0;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rst = 1; stall = 0; redirect = 0; redirect_target = 0; halt = 0;
        m_mode = 0; m_pc = RV; m_pcd = 0; m_pc4d = 0; m_instrd = NOP;
        m_valid = 0; m_err = 0; m_fc = 0; m_sc = 0;

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'hBFC00100, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'hBFC00102, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'hBFC00200, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, RV, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'hFFFFFFFC, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'hBFC00003, 1);
        cyc(0, 0, 1, 32'hBFC00040, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            tgt = RV + ($urandom_range(0, 4095) & 32'hFFFFFFFC);
            if ($urandom_range(0, 5) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFFFFFC;
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 19) == 0));
        end

        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
